i2c_regbank_ctrl: RTL and testbench

- Register-map controller that sits behind the byte-level I2C slave front end.
- Interprets the I2C byte stream as pointer-plus-data:
  - first written byte = register pointer;
  - following bytes write registers with auto-increment;
  - reads return bytes from the pointer with auto-increment.
- Arbitrates the register bank's single write port between the I2C side and a local host port.
- Exports all register contents flat for configuration of downstream logic.

---
 rtl/i2c_regbank_pkg.sv | 21 ++
 rtl/i2c_reg_array.sv | 55 +++++
 rtl/i2c_regbank_ctrl.sv | 150 +++++++++++++++
 tb/tb_i2c_regbank_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_regbank_pkg.sv
// ============================================================================
// Module   : i2c_regbank_pkg
// Purpose  : Shared state encoding and constants for the I2C register bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PTR = 2'd1,
        WRITE    = 2'd2,
        READ     = 2'd3
    } state_e;

    localparam logic [7:0] RD_FILL_DEFAULT = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/i2c_reg_array.sv
// ============================================================================
// Module   : i2c_reg_array
// Purpose  : NUM_REGS x 8 register storage, one write port, two read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_reg_array
    import i2c_regbank_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_W-1:0]     i2c_raddr,
    output logic [7:0]            i2c_rdata,
    input  logic [ADDR_W-1:0]     host_raddr,
    output logic [7:0]            host_rdata,
    output logic [NUM_REGS*8-1:0] reg_out
);

    logic [7:0] mem_q [NUM_REGS];
    logic [7:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign i2c_rdata  = mem_q[i2c_raddr];
    assign host_rdata = mem_q[host_raddr];

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
            assign reg_out[8*i +: 8] = mem_q[i];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/i2c_regbank_ctrl.sv
// ============================================================================
// Module   : i2c_regbank_ctrl
// Purpose  : Pointer-plus-data register map behind an I2C byte front end,
//            sharing the bank write port with a local host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_regbank_ctrl
    import i2c_regbank_pkg::*;
#(
    parameter int         NUM_REGS = 16,
    parameter int         ADDR_W   = 4,
    parameter logic [7:0] RD_FILL  = RD_FILL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i2c_start,
    input  logic                  i2c_rw,
    input  logic                  i2c_stop,
    input  logic                  i2c_wr_valid,
    input  logic [7:0]            i2c_wr_data,
    input  logic                  i2c_rd_req,
    output logic [7:0]            i2c_rd_data,
    output logic                  i2c_rd_valid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [7:0]            host_wdata,
    output logic                  host_ack,
    output logic [7:0]            host_rdata,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic                  busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              host_ack_q, host_ack_d;
    logic [7:0]        host_rdata_q, host_rdata_d;

    logic              i2c_we;
    logic              host_accept;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [7:0]        arr_wdata;
    logic [7:0]        arr_i2c_rdata;
    logic [7:0]        arr_host_rdata;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        i2c_we     = 1'b0;

        case (state_q)
            WAIT_PTR: begin
                if (i2c_wr_valid) begin
                    ptr_d   = i2c_wr_data[ADDR_W-1:0];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (i2c_wr_valid) begin
                    i2c_we = 1'b1;
                    ptr_d  = ptr_q + ADDR_W'(1);
                end
            end
            READ: begin
                if (i2c_rd_req) begin
                    rd_data_d  = arr_i2c_rdata;
                    rd_valid_d = 1'b1;
                    ptr_d      = ptr_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase

        if (i2c_rd_req && state_q != READ) begin
            rd_data_d  = RD_FILL;
            rd_valid_d = 1'b1;
        end

        // A byte arriving with STOP is still consumed above; START beats STOP.
        if (i2c_stop) begin
            state_d = IDLE;
        end
        if (i2c_start) begin
            state_d = i2c_rw ? READ : WAIT_PTR;
        end
    end

    // The I2C write owns the port; the host retries on the next free cycle.
    always_comb begin
        host_accept  = host_req && !host_ack_q && !i2c_we;
        host_ack_d   = host_accept;
        host_rdata_d = host_rdata_q;
        if (host_accept && !host_we) begin
            host_rdata_d = arr_host_rdata;
        end
        arr_we    = i2c_we || (host_accept && host_we);
        arr_waddr = i2c_we ? ptr_q : host_addr;
        arr_wdata = i2c_we ? i2c_wr_data : host_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    i2c_reg_array #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_reg_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (arr_we),
        .waddr      (arr_waddr),
        .wdata      (arr_wdata),
        .i2c_raddr  (ptr_q),
        .i2c_rdata  (arr_i2c_rdata),
        .host_raddr (host_addr),
        .host_rdata (arr_host_rdata),
        .reg_out    (reg_out)
    );

    assign i2c_rd_data  = rd_data_q;
    assign i2c_rd_valid = rd_valid_q;
    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_i2c_regbank_ctrl.sv
// ============================================================================
// Module   : tb_i2c_regbank_ctrl
// Purpose  : Directed self-checking bench for i2c_regbank_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_regbank_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i2c_start, i2c_rw, i2c_stop, i2c_wr_valid, i2c_rd_req;
    logic [7:0]   i2c_wr_data;
    logic [7:0]   i2c_rd_data;
    logic         i2c_rd_valid;
    logic         host_req, host_we;
    logic [3:0]   host_addr;
    logic [7:0]   host_wdata;
    logic         host_ack;
    logic [7:0]   host_rdata;
    logic [127:0] reg_out;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_regs [16];
    logic [3:0] m_ptr;
    int         m_state;
    logic [7:0] rd_q [$];
    logic [7:0] last_rd;

    always #5 clk = ~clk;

    i2c_regbank_ctrl #(
        .NUM_REGS (16),
        .ADDR_W   (4),
        .RD_FILL  (8'hFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i2c_start    (i2c_start),
        .i2c_rw       (i2c_rw),
        .i2c_stop     (i2c_stop),
        .i2c_wr_valid (i2c_wr_valid),
        .i2c_wr_data  (i2c_wr_data),
        .i2c_rd_req   (i2c_rd_req),
        .i2c_rd_data  (i2c_rd_data),
        .i2c_rd_valid (i2c_rd_valid),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .reg_out      (reg_out),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    // Scoreboard: every read-data pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && i2c_rd_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 1'b1, 1'b0);
            end else begin
                check("rd_data", i2c_rd_data, rd_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr   = 4'h0;
        m_state = 0;
    endtask

    task automatic start_t(input logic rw);
        @(negedge clk);
        i2c_start = 1'b1; i2c_rw = rw;
        @(negedge clk);
        i2c_start = 1'b0;
        m_state = rw ? 3 : 1;
    endtask

    task automatic stop_t();
        @(negedge clk);
        i2c_stop = 1'b1;
        @(negedge clk);
        i2c_stop = 1'b0;
        m_state = 0;
    endtask

    task automatic model_byte(input logic [7:0] d);
        if (m_state == 1) begin
            m_ptr   = d[3:0];
            m_state = 2;
        end else if (m_state == 2) begin
            m_regs[m_ptr] = d;
            m_ptr         = m_ptr + 4'd1;
        end
    endtask

    task automatic wr_byte(input logic [7:0] d);
        @(negedge clk);
        i2c_wr_valid = 1'b1; i2c_wr_data = d;
        @(negedge clk);
        i2c_wr_valid = 1'b0;
        model_byte(d);
    endtask

    task automatic rd_req_t();
        logic [7:0] e;
        @(negedge clk);
        if (m_state == 3) begin
            e     = m_regs[m_ptr];
            m_ptr = m_ptr + 4'd1;
        end else begin
            e = 8'hFF;
        end
        rd_q.push_back(e);
        last_rd    = e;
        i2c_rd_req = 1'b1;
        @(negedge clk);
        i2c_rd_req = 1'b0;
        check("rd_valid_latency", i2c_rd_valid, 1'b1);
    endtask

    task automatic host_access(input logic we, input logic [3:0] a, input logic [7:0] d);
        logic got;
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (host_ack === 1'b1) got = 1'b1;
        end
        host_req = 1'b0;
        check("host_ack", got, 1'b1);
        if (we) m_regs[a] = d;
        else    check("host_rdata", host_rdata, m_regs[a]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i2c_start = 0; i2c_rw = 0; i2c_stop = 0; i2c_wr_valid = 0; i2c_wr_data = 0;
        i2c_rd_req = 0; host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_reg_out", reg_out, 128'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_valid", i2c_rd_valid, 1'b0);
        check("rst_rd_data", i2c_rd_data, 8'h00);
        check("rst_host_ack", host_ack, 1'b0);
        check("rst_host_rdata", host_rdata, 8'h00);
        rst_n = 1'b1;

        // Write burst
        start_t(1'b0);
        check("busy_wait_ptr", busy, 1'b1);
        wr_byte(8'h03); wr_byte(8'hA1); wr_byte(8'hB2);
        check("burst_regs", reg_out, model_flat());
        stop_t();
        check("busy_after_stop", busy, 1'b0);
        host_access(1'b1, 4'd5, 8'h5A);
        start_t(1'b1);
        rd_req_t();
        stop_t();

        // Pointer write, repeated START, read
        start_t(1'b0);
        wr_byte(8'h03);
        start_t(1'b1);
        check("busy_read", busy, 1'b1);
        rd_req_t(); rd_req_t();
        repeat (2) @(negedge clk);
        check("rd_data_hold", i2c_rd_data, last_rd);
        check("rd_valid_low", i2c_rd_valid, 1'b0);
        host_access(1'b0, 4'd4, 8'h00);
        stop_t();

        // Pointer wrap, then masked pointer byte
        start_t(1'b0);
        wr_byte(8'h0F); wr_byte(8'h11); wr_byte(8'h22);
        check("wrap_regs", reg_out, model_flat());
        stop_t();
        start_t(1'b0); wr_byte(8'h25); stop_t();
        start_t(1'b1); rd_req_t(); stop_t();

        // Host/I2C collision on reg 2
        start_t(1'b0);
        wr_byte(8'h02);
        @(negedge clk);
        i2c_wr_valid = 1'b1; i2c_wr_data = 8'h77;
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'd2; host_wdata = 8'h55;
        @(negedge clk);
        i2c_wr_valid = 1'b0;
        model_byte(8'h77);
        check("collision_no_ack", host_ack, 1'b0);
        check("collision_i2c_first", reg_out, model_flat());
        @(negedge clk);
        check("collision_ack_late", host_ack, 1'b1);
        host_req = 1'b0;
        m_regs[2] = 8'h55;
        check("collision_host_wins", reg_out, model_flat());
        @(negedge clk);
        check("collision_ack_pulse", host_ack, 1'b0);
        stop_t();

        // Stray events
        rd_req_t();
        start_t(1'b1);
        rd_req_t();
        wr_byte(8'hEE);
        check("wr_in_read_ignored", reg_out, model_flat());
        stop_t();

        // Byte with STOP, START with STOP
        start_t(1'b0);
        wr_byte(8'h08);
        @(negedge clk);
        i2c_wr_valid = 1'b1; i2c_wr_data = 8'h3C; i2c_stop = 1'b1;
        @(negedge clk);
        i2c_wr_valid = 1'b0; i2c_stop = 1'b0;
        model_byte(8'h3C); m_state = 0;
        check("byte_with_stop_regs", reg_out, model_flat());
        check("byte_with_stop_idle", busy, 1'b0);
        @(negedge clk);
        i2c_start = 1'b1; i2c_rw = 1'b0; i2c_stop = 1'b1;
        @(negedge clk);
        i2c_start = 1'b0; i2c_stop = 1'b0; m_state = 1;
        check("start_beats_stop", busy, 1'b1);

        // Reset mid-write
        wr_byte(8'h07);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("midrst_regs", reg_out, 128'h0);
        check("midrst_busy", busy, 1'b0);
        wr_byte(8'h99);
        check("post_rst_wr_ignored", reg_out, model_flat());
        start_t(1'b1); rd_req_t(); stop_t();

        repeat (2) @(negedge clk);
        check("scoreboard_drained", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
